// File: rtl/mdc_pkg.sv
// rtl/mdc_pkg.sv - shared helpers for the radix-2 MDC FFT stage
package mdc_pkg;

    localparam int DEF_DW = 32;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    // Half-LSB of the sliced product; added before the slice when rounding is enabled.
    function automatic logic [127:0] round_bias(input int frac);
        return (frac > 0) ? (128'd1 << (frac - 1)) : '0;
    endfunction

    function automatic logic [2*DEF_DW-1:0] cx_join(input logic [DEF_DW-1:0] re,
                                                    input logic [DEF_DW-1:0] im);
        return {re, im};
    endfunction

    function automatic logic [DEF_DW-1:0] cx_re(input logic [2*DEF_DW-1:0] w);
        return w[2*DEF_DW-1:DEF_DW];
    endfunction

    function automatic logic [DEF_DW-1:0] cx_im(input logic [2*DEF_DW-1:0] w);
        return w[DEF_DW-1:0];
    endfunction

endpackage

// File: rtl/mdc_cmul.sv
// rtl/mdc_cmul.sv - combinational B * conj-form twiddle multiply (MDC_ROUND_EN: round half up)
module mdc_cmul
    import mdc_pkg::*;
#(
    parameter int DW   = 32,
    parameter int FRAC = 16
) (
    input  logic [2*DW-1:0] i_b,
    input  logic [2*DW-1:0] i_tf,
    output logic [2*DW-1:0] o_m
);

`ifdef MDC_ROUND_EN
    localparam logic [2*DW-1:0] BIAS = (2*DW)'(round_bias(FRAC));
`else
    localparam logic [2*DW-1:0] BIAS = '0;
`endif

    logic signed [DW-1:0]   w_br, w_bi, w_c, w_s;
    logic signed [2*DW-1:0] w_p_rc, w_p_is, w_p_ic, w_p_rs;

    assign w_br = i_b[2*DW-1:DW];
    assign w_bi = i_b[DW-1:0];
    assign w_c  = i_tf[2*DW-1:DW];
    assign w_s  = i_tf[DW-1:0];

    assign w_p_rc = (2*DW)'(w_br) * (2*DW)'(w_c);
    assign w_p_is = (2*DW)'(w_bi) * (2*DW)'(w_s);
    assign w_p_ic = (2*DW)'(w_bi) * (2*DW)'(w_c);
    assign w_p_rs = (2*DW)'(w_br) * (2*DW)'(w_s);

    // Each product is biased and sliced on its own; the sums then wrap at DW bits.
    assign o_m[2*DW-1:DW] = DW'((w_p_rc + BIAS) >> FRAC) + DW'((w_p_is + BIAS) >> FRAC);
    assign o_m[DW-1:0]    = DW'((w_p_ic + BIAS) >> FRAC) - DW'((w_p_rs + BIAS) >> FRAC);

endmodule

// File: rtl/mdc_r2_stage.sv
// rtl/mdc_r2_stage.sv - radix-2 MDC stage: butterfly, twiddle, DEPTH-deep commutator (MDC_ROUND_EN)
module mdc_r2_stage
    import mdc_pkg::*;
#(
    parameter int DW    = 32,
    parameter int FRAC  = 16,
    parameter int DEPTH = 4
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_valid,
    input  logic                         i_sof,
    input  logic [2*DW-1:0]              i_d0,
    input  logic [2*DW-1:0]              i_d1,
    output logic [clog2(2*DEPTH)-1:0]    o_tw_idx,
    input  logic [2*DW-1:0]              i_tf,
    output logic                         o_valid,
    output logic [2*DW-1:0]              o_q0,
    output logic [2*DW-1:0]              o_q1
);

    localparam int CW   = clog2(2*DEPTH);
    localparam int SELB = clog2(DEPTH);
    localparam int W    = 2*DW;

    logic [CW-1:0] r_cnt, w_cnt, r_prime;
    logic [W-1:0]  w_a, w_b, w_m;
    logic [W-1:0]  r_s_a, r_s_m;
    logic          r_s_sel, r_s_vld;
    logic [W-1:0]  r_line_m [DEPTH];
    logic [W-1:0]  r_line_0 [DEPTH];
    logic [W-1:0]  w_l, w_line0_in, w_q0n, w_q1n;
    logic [W-1:0]  r_q0, r_q1;
    logic          r_out_valid;

    // A start-of-frame beat is processed as beat 0 of the frame.
    assign w_cnt    = (i_valid && i_sof) ? '0 : r_cnt;
    assign o_tw_idx = w_cnt;

    assign w_a = {i_d0[W-1:DW] + i_d1[W-1:DW], i_d0[DW-1:0] + i_d1[DW-1:0]};
    assign w_b = {i_d0[W-1:DW] - i_d1[W-1:DW], i_d0[DW-1:0] - i_d1[DW-1:0]};

    mdc_cmul #(.DW(DW), .FRAC(FRAC)) u_cmul (
        .i_b  (w_b),
        .i_tf (i_tf),
        .o_m  (w_m)
    );

    assign w_l        = r_line_m[DEPTH-1];
    assign w_line0_in = r_s_sel ? w_l : r_s_a;
    assign w_q1n      = r_s_sel ? r_s_a : w_l;
    assign w_q0n      = r_line_0[DEPTH-1];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt       <= '0;
            r_prime     <= '0;
            r_s_a       <= '0;
            r_s_m       <= '0;
            r_s_sel     <= 1'b0;
            r_s_vld     <= 1'b0;
            r_q0        <= '0;
            r_q1        <= '0;
            r_out_valid <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_line_m[i] <= '0;
                r_line_0[i] <= '0;
            end
        end else begin
            r_out_valid <= i_valid && r_s_vld && (r_prime >= CW'(DEPTH));
            if (i_valid) begin
                r_cnt       <= w_cnt + CW'(1);
                r_s_a       <= w_a;
                r_s_m       <= w_m;
                r_s_sel     <= w_cnt[SELB];
                r_s_vld     <= 1'b1;
                r_line_m[0] <= r_s_m;
                r_line_0[0] <= w_line0_in;
                for (int i = 1; i < DEPTH; i++) begin
                    r_line_m[i] <= r_line_m[i-1];
                    r_line_0[i] <= r_line_0[i-1];
                end
                // Only beats carrying real stage data count towards priming.
                if (r_s_vld && (r_prime < CW'(DEPTH)))
                    r_prime <= r_prime + CW'(1);
                r_q0 <= w_q0n;
                r_q1 <= w_q1n;
            end
        end
    end

    assign o_valid = r_out_valid;
    assign o_q0    = r_q0;
    assign o_q1    = r_q1;

endmodule

// File: tb/tb_mdc_r2_stage.sv
// tb/tb_mdc_r2_stage.sv - directed table-driven bench for mdc_r2_stage (DEPTH 1 and 2)
module tb_mdc_r2_stage;

    logic        clk;
    logic        rst_n;
    logic        valid;
    logic        sof;
    logic [63:0] d0, d1, tf;
    logic [0:0]  tw1;
    logic [1:0]  tw2;
    logic        ov1, ov2;
    logic [63:0] q0_1, q1_1, q0_2, q1_2;

    int n_chk  = 0;
    int n_pass = 0;

    mdc_r2_stage #(.DW(32), .FRAC(16), .DEPTH(1)) u_d1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .i_sof(sof),
        .i_d0(d0), .i_d1(d1), .o_tw_idx(tw1), .i_tf(tf),
        .o_valid(ov1), .o_q0(q0_1), .o_q1(q1_1)
    );

    mdc_r2_stage #(.DW(32), .FRAC(16), .DEPTH(2)) u_d2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .i_sof(sof),
        .i_d0(d0), .i_d1(d1), .o_tw_idx(tw2), .i_tf(tf),
        .o_valid(ov2), .o_q0(q0_2), .o_q1(q1_2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1);
    end

    typedef struct {
        bit          rst;
        bit          dsel;
        logic [63:0] d0, d1, tf;
        bit          ov;
        logic [63:0] q0, q1;
        int          tw;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [63:0] cx(input int re, input int im);
        return {re[31:0], im[31:0]};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s act=%h exp=%h", name, act, exp);
    endtask

    task automatic add(input bit rst, input bit dsel, input logic [63:0] a0, input logic [63:0] a1,
                       input logic [63:0] t, input bit ov, input logic [63:0] e0,
                       input logic [63:0] e1, input int tw);
        vec_t v;
        v.rst = rst; v.dsel = dsel; v.d0 = a0; v.d1 = a1; v.tf = t;
        v.ov = ov; v.q0 = e0; v.q1 = e1; v.tw = tw;
        tbl.push_back(v);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        valid = 1'b0;
        sof   = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    function automatic int pair_lo(input int j);
        return ((j - 2) / 4) * 4 + (j % 2);
    endfunction

    logic [63:0] got0[$];
    logic [63:0] got1[$];

    task automatic sample_gap(input bit beat);
        if (beat) begin
            if (ov2) begin
                got0.push_back(q0_2);
                got1.push_back(q1_2);
            end
        end else begin
            chk("gap_ov", 64'(ov2), 64'd0);
        end
    endtask

    initial begin
        logic [63:0] ea, em, tmp;
        int rm;
        int ng;
        rst_n = 1'b1; valid = 1'b0; sof = 1'b0;
        d0 = '0; d1 = '0; tf = '0;

`ifdef MDC_ROUND_EN
        rm = 1;
`else
        rm = 0;
`endif
        // DEPTH=1 identity twiddle: pairs alternate (A,A) and (M,M).
        for (int r = 0; r < 6; r++)
            add(r == 0, 1'b0, cx(3, 0), cx(1, 0), cx(65536, 0), r >= 2,
                (r % 2 == 0) ? cx(4, 0) : cx(2, 0), (r % 2 == 0) ? cx(4, 0) : cx(2, 0), r % 2);
        // Quarter-turn rotation.
        ea = cx(65536, 0);
        em = cx(0, -65536);
        for (int r = 0; r < 4; r++)
            add(r == 0, 1'b0, cx(65536, 0), 64'd0, cx(0, 65536), r >= 2,
                (r % 2 == 0) ? ea : em, (r % 2 == 0) ? ea : em, r % 2);
        // Half-LSB product: rounding changes M.re from 0 to 1.
        ea = cx(1, 0);
        em = cx(rm, 0);
        for (int r = 0; r < 4; r++)
            add(r == 0, 1'b0, cx(1, 0), 64'd0, cx(32768, 0), r >= 2,
                (r % 2 == 0) ? ea : em, (r % 2 == 0) ? ea : em, r % 2);
        // DEPTH=2 ordering with A=M=k.
        for (int r = 0; r < 11; r++)
            add(r == 0, 1'b1, cx(r, 0), 64'd0, cx(65536, 0), r >= 3,
                cx(pair_lo(r - 1), 0), cx(pair_lo(r - 1) + 2, 0), r % 4);

        // Reset state.
        do_reset();
        chk("rst_ov1", 64'(ov1), 64'd0);
        chk("rst_q0_2", q0_2, 64'd0);
        chk("rst_tw2", 64'(tw2), 64'd0);

        foreach (tbl[i]) begin
            if (tbl[i].rst) do_reset();
            valid = 1'b1; sof = 1'b0;
            d0 = tbl[i].d0; d1 = tbl[i].d1; tf = tbl[i].tf;
            #1;
            if (tbl[i].dsel) chk($sformatf("tw2_r%0d", i), 64'(tw2), 64'(tbl[i].tw));
            else             chk($sformatf("tw1_r%0d", i), 64'(tw1), 64'(tbl[i].tw));
            @(posedge clk);
            #1;
            if (tbl[i].dsel) begin
                chk($sformatf("ov2_r%0d", i), 64'(ov2), 64'(tbl[i].ov));
                if (tbl[i].ov) begin
                    chk($sformatf("q0_2_r%0d", i), q0_2, tbl[i].q0);
                    chk($sformatf("q1_2_r%0d", i), q1_2, tbl[i].q1);
                end
            end else begin
                chk($sformatf("ov1_r%0d", i), 64'(ov1), 64'(tbl[i].ov));
                if (tbl[i].ov) begin
                    chk($sformatf("q0_1_r%0d", i), q0_1, tbl[i].q0);
                    chk($sformatf("q1_1_r%0d", i), q1_1, tbl[i].q1);
                end
            end
        end

        // Asynchronous reset mid-stream clears outputs without a clock edge.
        do_reset();
        tf = cx(65536, 0); d1 = '0; valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            d0 = cx(k + 1, 0);
            @(posedge clk);
            #1;
        end
        chk("pre_rst_ov2", 64'(ov2), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ov2", 64'(ov2), 64'd0);
        chk("mid_rst_q0_2", q0_2, 64'd0);
        chk("mid_rst_q1_2", q1_2, 64'd0);
        chk("mid_rst_tw2", 64'(tw2), 64'd0);
        chk("mid_rst_q1_1", q1_1, 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Same DEPTH=2 stream with random gaps: identical pair sequence.
        do_reset();
        got0.delete(); got1.delete();
        for (int k = 0; k < 11; k++) begin
            valid = 1'b1; d0 = cx(k, 0); d1 = '0;
            @(posedge clk);
            #1;
            sample_gap(1'b1);
            ng = int'($urandom_range(1, 3));
            for (int g = 0; g < ng; g++) begin
                valid = 1'b0;
                d0 = cx(int'($urandom), int'($urandom));
                @(posedge clk);
                #1;
                sample_gap(1'b0);
            end
        end
        chk("gap_count", 64'(got0.size()), 64'd8);
        for (int j = 2; j < 10; j++) begin
            tmp = (got0.size() > j - 2) ? got0[j-2] : 64'hDEAD;
            chk($sformatf("gap_q0_j%0d", j), tmp, cx(pair_lo(j), 0));
            tmp = (got1.size() > j - 2) ? got1[j-2] : 64'hDEAD;
            chk($sformatf("gap_q1_j%0d", j), tmp, cx(pair_lo(j) + 2, 0));
        end

        // Start of frame on beat 3 realigns the counter.
        do_reset();
        for (int k = 0; k < 5; k++) begin
            valid = 1'b1; sof = (k == 3); d0 = cx(k, 0);
            #1;
            if (k < 3) chk($sformatf("sof_tw2_b%0d", k), 64'(tw2), 64'(k));
            if (k == 3) begin
                chk("sof_tw2_b3", 64'(tw2), 64'd0);
                chk("sof_tw1_b3", 64'(tw1), 64'd0);
            end
            if (k == 4) begin
                chk("sof_tw2_b4", 64'(tw2), 64'd1);
                chk("sof_tw1_b4", 64'(tw1), 64'd1);
            end
            @(posedge clk);
            #1;
        end
        valid = 1'b0; sof = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
